irq_ctrl: RTL
=============

# irq_ctrl

Machine-level interrupt controller that sits directly upstream of the CSR register file and drives its `int_req` input. It synchronises `N_SRC` asynchronous interrupt lines, latches them as pending, masks them with a software-writable enable register and selects the highest-priority line. It then holds a single request to the core until the trap is taken, and blocks further requests until the handler executes `mret`.

## Interface
Parameters:
- `N_SRC`, 4, number of interrupt source lines.
- `ID_W`, 2, width of `irq_id`; must satisfy 2**ID_W >= N_SRC.
- `EN_RST`, {N_SRC{1'b1}}, reset value of the enable register.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `irq_src`  in  N_SRC  raw asynchronous interrupt lines, active high.
- `en_we`  in  1  write strobe for the enable register.
- `en_wdata`  in  N_SRC  new enable mask.
- `int_ack`  in  1  one-cycle pulse from the core when it redirects to mtvec.
- `ret`  in  1  one-cycle pulse when the core executes mret.
- `int_req`  out  1  interrupt request to the CSR file.
- `irq_id`  out  ID_W  index of the requesting source, valid while `int_req` is high.
- `pending`  out  N_SRC  current pending bits, used for debug/MMIO readback.
- `enable`  out  N_SRC  current enable mask.

## Operation
- Each `irq_src` bit passes through a 2-flop synchroniser, producing `sync`.
- Detection mode depends on the configuration (see below). A detected source sets `pending[i]`.
- Selection: `sel` = lowest index i with `pending[i] & enable[i]`. Index 0 has the highest priority.
- The FSM has three states:
  - IDLE: `int_req`=0. Moves to REQ when any `pending & enable` bit is set; latches `irq_id`=`sel`.
  - REQ: `int_req`=1. `irq_id` is frozen. Moves to SERVICE on `int_ack`, and clears `pending[irq_id]` in edge mode.
  - SERVICE: `int_req`=0. Moves to IDLE on `ret`.
- `ret` is ignored in IDLE and REQ. `int_ack` is ignored in IDLE and SERVICE.
- If `int_ack` and `ret` arrive in the same cycle while in REQ, `int_ack` wins (→ SERVICE).
- Clearing `enable[irq_id]` while in REQ does not withdraw the request. The request is held until `int_ack`.
- If a pending set and an ack-clear hit the same bit in the same cycle, the set wins and the bit stays pending.
- `en_we` writes `enable` on the clock edge, in any state.
- Reset, including mid-REQ or mid-SERVICE: state=IDLE, `int_req`=0, `irq_id`=0, `pending`=0, synchronisers=0, `enable`=`EN_RST`.

## Timing
- If `irq_src[i]` rises before edge k: `sync` is high after k+1, `pending[i]` after k+2, `int_req` after k+3 (3-cycle latency).
- `int_req` is a decode of the state flop, with no combinational path from inputs.
- `int_ack` sampled at edge m drops `int_req` after edge m.
- The earliest re-request is 1 cycle after the `ret` edge, provided pending and enabled bits exist.
- An enable write at edge k is visible to selection in cycle k+1.

## Configuration
- `IRQ_CTRL_EDGE_EN` defined (edge mode):
  - `pending[i]` is set on a rising edge of `sync[i]`, using a third delay flop.
  - `pending[i]` is cleared only by the matching `int_ack`.
  - A pulse of at least 2 clocks is captured even after it deasserts.
- Not defined (level mode):
  - `pending` is a registered copy of `sync`.
  - `int_ack` does not clear it; the source must be cleared by the handler.
  - If the level is still high after `ret`, the source re-requests.

## Structure
- Shared package `irq_ctrl_pkg`: FSM state enum (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), `N_SRC`/`ID_W` defaults, and the mcause value 32'h8000000b used by the CSR file.
- Sub-module `irq_sync_det`: one instance per source, containing the synchroniser and edge/level detect. It outputs a one-cycle set pulse in edge mode, or the level in level mode.
- The priority encoder and FSM live in the top module.

## Test plan
- Reset: hold `reset_n`=0 with `irq_src`=4'b1111 → `int_req`=0, `pending`=0, `enable`=4'b1111; after release, `int_req` rises exactly 3 edges later with `irq_id`=0.
- Priority: raise `irq_src`=4'b1010 together → `irq_id`=1; ack then `ret` → next request has `irq_id`=3 (edge mode).
- Handshake: in REQ, drive `int_ack` and `ret` in the same cycle → state is SERVICE and `int_req`=0; `ret` alone in IDLE has no effect.
- Masking: write `enable`=4'b1110, pulse `irq_src[0]` for 2 cycles → no request and `pending`=4'b0001; write 4'b1111 → `int_req` the next cycle with `irq_id`=0.
- Collision: a new edge on source 2 in the same cycle as `int_ack` for `irq_id`=2 → `pending[2]` stays 1 and re-requests after `ret`.
- Reset in SERVICE: assert `reset_n`=0 asynchronously mid-handler → outputs clear immediately, without waiting for a clock edge; a later `ret` is ignored.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the machine-level interrupt controller.
package irq_ctrl_pkg;

    localparam int unsigned N_SRC_DEF    = 4;
    localparam int unsigned ID_W_DEF     = 2;
    localparam logic [31:0] MCAUSE_M_EXT = 32'h8000_000b;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_sync_det.sv
// Per-source 2-flop synchroniser plus detector; IRQ_CTRL_EDGE_EN selects
// a one-cycle rising-edge pulse, otherwise the synchronised level is passed on.
module irq_sync_det (
    input  logic clock,
    input  logic reset_n,
    input  logic irq_src,
    output logic det
);

    logic meta;
    logic sync;

`ifdef IRQ_CTRL_EDGE_EN
    logic sync_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= irq_src;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign det = sync & ~sync_d;
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= irq_src;
            sync <= meta;
        end
    end

    assign det = sync;
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: pending/enable registers, fixed-priority select
// and request FSM. Define IRQ_CTRL_EDGE_EN for edge-triggered pending bits.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned           N_SRC  = N_SRC_DEF,
    parameter int unsigned           ID_W   = ID_W_DEF,
    parameter logic [N_SRC-1:0]      EN_RST = '1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             en_we,
    input  logic [N_SRC-1:0] en_wdata,
    input  logic             int_ack,
    input  logic             ret,
    output logic             int_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] enable
);

    irq_state_e       state;
    logic [N_SRC-1:0] det;
    logic [N_SRC-1:0] active;
    logic             any_active;
    logic [ID_W-1:0]  sel;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        irq_sync_det u_det (
            .clock   (clock),
            .reset_n (reset_n),
            .irq_src (irq_src[g]),
            .det     (det[g])
        );
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [N_SRC-1:0] ack_clr;

    assign ack_clr = (state == REQ && int_ack) ? (N_SRC'(1) << irq_id) : '0;

    // OR-ing the set pulse after the clear lets a coincident new edge survive the ack
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= (pending & ~ack_clr) | det;
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= det;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   enable <= EN_RST;
        else if (en_we) enable <= en_wdata;
    end

    always_comb begin
        logic found;
        active     = pending & enable;
        any_active = |active;
        sel        = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (active[i] && !found) begin
                sel   = ID_W'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            int_req <= 1'b0;
            irq_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_active) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        irq_id  <= sel;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state   <= SERVICE;
                        int_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (ret) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
